// File: rtl/la_checkpoint_monitor.sv
// Decodes firmware checkpoint codes from la_output[31:16]: per-test sequencing, watchdog, sticky flags.
// Optional LA_MON_LOG_EN adds code_log, a history of the last four recognized codes.
module la_checkpoint_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 300000,
    parameter logic [3:0]  FINAL_ID       = 4'h1
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic [15:0] checkbits,
    input  logic        clear,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        seq_err,
    output logic        timeout,
    output logic [3:0]  fail_id,
`ifdef LA_MON_LOG_EN
    output logic [63:0] code_log,
`endif
    output logic [3:0]  pass_count
);

    // state   | meaning
    // IDLE    | between tests, waiting for a start code
    // RUN     | test cur_id started, waiting for its pass/fail
    // DONE    | pass of FINAL_ID accepted (terminal)
    // FAIL_ST | fail code or sequence error (terminal)
    // TMO     | watchdog expired (terminal)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd2;
    localparam logic [2:0] ST_FAIL = 3'd3;
    localparam logic [2:0] ST_TMO  = 3'd4;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state_q, state_d;
    logic [15:0]     cb_q, checkbits_q2;
    logic [3:0]      cur_id_q, cur_id_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic            seq_err_q, seq_err_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      fail_id_q, fail_id_d;
    logic [3:0]      pass_count_q, pass_count_d;
    logic [63:0]     code_log_q, code_log_d;

    logic       event_w;
    logic       is_start, is_fail, is_pass, recognized;
    logic       live;
    logic [3:0] code_id;

    assign event_w    = (cb_q != checkbits_q2);
    assign code_id    = cb_q[7:4];
    assign is_start   = (cb_q[15:8] == 8'hA0) && (cb_q[3:0] == 4'h0);
    assign is_fail    = (cb_q[15:8] == 8'hAB) && (cb_q[3:0] == 4'h0);
    assign is_pass    = (cb_q[15:8] == 8'hAB) && (cb_q[3:0] == 4'h1);
    assign recognized = event_w && (is_start || is_fail || is_pass);
    assign live       = (state_q == ST_IDLE) || (state_q == ST_RUN);

    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        wdog_d       = wdog_q;
        done_d       = done_q;
        fail_d       = fail_q;
        seq_err_d    = seq_err_q;
        timeout_d    = timeout_q;
        fail_id_d    = fail_id_q;
        pass_count_d = pass_count_q;
        code_log_d   = code_log_q;

        if (live && recognized) begin
            code_log_d = {code_log_q[47:0], cb_q};
        end

        case (state_q)
            ST_IDLE: begin
                if (recognized) begin
                    if (is_start) begin
                        state_d  = ST_RUN;
                        cur_id_d = code_id;
                    end else begin
                        state_d   = ST_FAIL;
                        seq_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (recognized) begin
                    if (is_pass && (code_id == cur_id_q)) begin
                        if (pass_count_q != 4'hF) begin
                            pass_count_d = pass_count_q + 4'd1;
                        end
                        state_d = (code_id == FINAL_ID) ? ST_DONE : ST_IDLE;
                    end else if (is_fail && (code_id == cur_id_q)) begin
                        state_d   = ST_FAIL;
                        seq_err_d = 1'b0;
                    end else begin
                        state_d   = ST_FAIL;
                        seq_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Only a terminal-causing event beats the watchdog; a start or mid-run pass is dropped.
        if (live && (wdog_q == WD_LAST) && (state_d != ST_DONE) && (state_d != ST_FAIL)) begin
            state_d      = ST_TMO;
            timeout_d    = 1'b1;
            cur_id_d     = cur_id_q;
            pass_count_d = pass_count_q;
            seq_err_d    = seq_err_q;
        end

        if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) begin
            fail_d    = 1'b1;
            fail_id_d = code_id;
        end
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
        if (live) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    assign busy_d = (state_d == ST_IDLE) || (state_d == ST_RUN);

    always_ff @(posedge core_clk) begin
        if (core_rst || clear) begin
            state_q      <= ST_IDLE;
            cb_q         <= 16'h0000;
            checkbits_q2 <= 16'h0000;
            cur_id_q     <= 4'h0;
            wdog_q       <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            seq_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            fail_id_q    <= 4'h0;
            pass_count_q <= 4'h0;
            code_log_q   <= 64'h0;
        end else begin
            state_q      <= state_d;
            cb_q         <= checkbits;
            checkbits_q2 <= cb_q;
            cur_id_q     <= cur_id_d;
            wdog_q       <= wdog_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            seq_err_q    <= seq_err_d;
            timeout_q    <= timeout_d;
            fail_id_q    <= fail_id_d;
            pass_count_q <= pass_count_d;
            code_log_q   <= code_log_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign seq_err    = seq_err_q;
    assign timeout    = timeout_q;
    assign fail_id    = fail_id_q;
    assign pass_count = pass_count_q;

`ifdef LA_MON_LOG_EN
    assign code_log = code_log_q;
`else
    // History is tracked unconditionally; without the port it simply has no load.
    logic unused_log;
    assign unused_log = ^code_log_q;
`endif

endmodule
